// File: rtl/mem_fill_responder.sv
// Fixed-latency memory model that answers cache line fills and line writes.
// One transaction at a time: a request accepted in IDLE waits LATENCY edges,
// then completes with a one-cycle dready pulse. Requests seen while busy are
// dropped without queuing.
//
// Ports:
//   CLK, reset     clock and synchronous active-high reset
//   req            request strobe, sampled only when idle
//   addr           byte address of the request
//   wr             1 = 64-bit write, 0 = line read
//   line128        1 = 128-bit line, 0 = 64-bit line (reads only)
//   wdata          write line, [63:32] lands at the lower address
//   rdata          returned line, held until the next read completes
//   dready         one-cycle completion pulse
//   busy           a transaction is in flight
module mem_fill_responder #(
  parameter int unsigned LATENCY    = 20,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         req,
  input  logic [31:0]  addr,
  input  logic         wr,
  input  logic         line128,
  input  logic [63:0]  wdata,
  output logic [127:0] rdata,
  output logic         dready,
  output logic         busy
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic                    dready_d, busy_d;
  logic                    accept, finish;

  logic [31:0]             aligned;
  logic [DEPTH_LOG2-1:0]   idx_in;
  logic [DEPTH_LOG2-1:0]   idx_q, idx1, idx2, idx3;
  logic                    wr_q, line_q;
  logic [63:0]             wdata_q;
  logic                    unused_bits;

  logic [31:0]             mem [WORDS];

  // Writes are always 64-bit, so only a 128-bit read clears addr[3].
  always_comb begin
    aligned      = addr;
    aligned[2:0] = 3'b000;
    if (line128 && !wr) aligned[3] = 1'b0;
  end

  // Upper address bits fall away, so addresses wrap modulo the store size.
  assign idx_in      = aligned[DEPTH_LOG2+1:2];
  assign unused_bits = ^{aligned[31:DEPTH_LOG2+2], aligned[1:0]};

  assign idx1 = idx_q + DEPTH_LOG2'(1);
  assign idx2 = idx_q + DEPTH_LOG2'(2);
  assign idx3 = idx_q + DEPTH_LOG2'(3);

  // State register and registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      dready <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      dready <= dready_d;
      busy   <= busy_d;
    end
  end

  // Next state: counter is loaded with LATENCY-1 at acceptance so the
  // completion edge lands exactly LATENCY edges later (LATENCY=1 loads 0).
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          finish  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dready_d = finish;
    busy_d   = (state_d != IDLE);
  end

  // Request capture at acceptance and read-line return at completion.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rdata   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      line_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        idx_q   <= idx_in;
        wr_q    <= wr;
        line_q  <= line128 & ~wr;
        wdata_q <= wdata;
      end
      if (finish && !wr_q) begin
        if (line_q) rdata <= {mem[idx_q], mem[idx1], mem[idx2], mem[idx3]};
        else        rdata <= {64'h0, mem[idx_q], mem[idx1]};
      end
    end
  end

  // Backing store keeps its contents across reset; reset blocks the commit.
  always_ff @(posedge CLK) begin
    if (!reset && finish && wr_q) begin
      mem[idx_q] <= wdata_q[63:32];
      mem[idx1]  <= wdata_q[31:0];
    end
  end

endmodule

// File: tb/tb_mem_fill_responder.sv
// Self-checking bench for mem_fill_responder: default build (LATENCY=20)
// plus a LATENCY=1 build, with a queue-based scoreboard over a word model.
module tb_mem_fill_responder;

  localparam int LAT = 20;
  localparam int unsigned MASK = 32'hFFF;

  typedef struct packed {
    logic        w;
    logic        l;
    logic [31:0] wi;
    logic [63:0] d;
  } txn_t;

  logic         clk, reset, req, req1, wr, line128;
  logic [31:0]  addr;
  logic [63:0]  wdata;
  logic [127:0] rdata, rdata1;
  logic         dready, busy, dready1, busy1;

  int tests_run    = 0;
  int tests_failed = 0;

  txn_t         sb[$];
  logic [31:0]  mm [int unsigned];
  logic [127:0] model_rdata;

  mem_fill_responder #(.LATENCY(LAT), .DEPTH_LOG2(12)) u_dut (
    .CLK(clk), .reset(reset), .req(req), .addr(addr), .wr(wr),
    .line128(line128), .wdata(wdata), .rdata(rdata), .dready(dready), .busy(busy)
  );

  mem_fill_responder #(.LATENCY(1), .DEPTH_LOG2(12)) u_dut1 (
    .CLK(clk), .reset(reset), .req(req1), .addr(addr), .wr(wr),
    .line128(line128), .wdata(wdata), .rdata(rdata1), .dready(dready1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mget(input logic [31:0] wi);
    int unsigned k;
    k = wi & MASK;
    return mm.exists(k) ? mm[k] : 32'h0;
  endfunction

  // Pop the oldest outstanding transaction and compare the DUT's rdata.
  task automatic check_resp(input string name);
    txn_t t;
    logic [127:0] exp;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: dready with no outstanding request", name);
      return;
    end
    t = sb.pop_front();
    if (t.w) begin
      mm[t.wi & MASK]           = t.d[63:32];
      mm[(t.wi + 32'd1) & MASK] = t.d[31:0];
      exp = model_rdata;
    end else if (t.l) begin
      exp = {mget(t.wi), mget(t.wi + 32'd1), mget(t.wi + 32'd2), mget(t.wi + 32'd3)};
    end else begin
      exp = {64'h0, mget(t.wi), mget(t.wi + 32'd1)};
    end
    model_rdata = exp;
    if (rdata !== exp) begin
      tests_failed++;
      $display("FAIL %s rdata: got %h expected %h", name, rdata, exp);
    end
  endtask

  function automatic txn_t make_txn(input logic w, input logic [31:0] a,
                                    input logic l, input logic [63:0] d);
    txn_t t;
    t.w  = w;
    t.l  = l & ~w;
    t.wi = ((w || !l) ? (a & ~32'h7) : (a & ~32'hF)) >> 2;
    t.d  = d;
    return t;
  endfunction

  // One full transaction; inputs are scrambled right after acceptance.
  task automatic do_txn(input string name, input logic w, input logic [31:0] a,
                        input logic l, input logic [63:0] d);
    int got;
    txn_t t;
    sb.push_back(make_txn(w, a, l, d));
    req = 1'b1; wr = w; addr = a; line128 = l; wdata = d;
    tick();
    req = 1'b0; addr = $urandom; wr = ~w; line128 = ~l; wdata = {$urandom, $urandom};
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s accept: busy got %b expected 1", name, busy);
    end
    got = -1;
    for (int j = 1; j <= LAT + 4; j++) begin
      tick();
      if (dready === 1'b1) begin
        got = j;
        break;
      end
    end
    tests_run++;
    if (got != LAT) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d expected %0d", name, got, LAT);
    end
    if (got > 0) begin
      check_resp(name);
      tick();
      tests_run++;
      if (dready !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s end: dready=%b busy=%b expected 0 0", name, dready, busy);
      end
    end else if (sb.size() > 0) begin
      t = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; req1 = 1'b1;
    tick(); tick();
    req = 1'b0; req1 = 1'b0;
    tests_run++;
    if (dready !== 1'b0 || busy !== 1'b0 || rdata !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset: dready=%b busy=%b rdata=%h expected 0 0 0", dready, busy, rdata);
    end
    tests_run++;
    if (dready1 !== 1'b0 || busy1 !== 1'b0 || rdata1 !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_lat1: dready=%b busy=%b rdata=%h expected 0 0 0", dready1, busy1, rdata1);
    end
    reset = 1'b0;
    model_rdata = '0;
    tick();
  endtask

  task automatic test_read128();
    do_txn("pre_100", 1'b1, 32'h0000_0100, 1'b1, 64'h11111111_22222222);
    do_txn("pre_108", 1'b1, 32'h0000_0108, 1'b0, 64'h33333333_44444444);
    do_txn("read128", 1'b0, 32'h0000_0108, 1'b1, 64'h0);
    tests_run++;
    if (rdata !== 128'h11111111_22222222_33333333_44444444) begin
      tests_failed++;
      $display("FAIL read128 const: got %h expected 11111111222222223333333344444444", rdata);
    end
  endtask

  task automatic test_write_read64();
    do_txn("wr64", 1'b1, 32'h0000_0204, 1'b1, 64'hDEADBEEF_CAFEF00D);
    do_txn("rd64", 1'b0, 32'h0000_0200, 1'b0, 64'h0);
    tests_run++;
    if (rdata !== {64'h0, 64'hDEADBEEF_CAFEF00D}) begin
      tests_failed++;
      $display("FAIL rd64 const: got %h expected 0000000000000000deadbeefcafef00d", rdata);
    end
  endtask

  task automatic test_hold();
    logic [127:0] snap;
    snap = rdata;
    for (int j = 0; j < 5; j++) tick();
    tests_run++;
    if (rdata !== snap) begin
      tests_failed++;
      $display("FAIL hold: got %h expected %h", rdata, snap);
    end
    do_txn("wr_keeps_rdata", 1'b1, 32'h0000_0500, 1'b0, 64'h01020304_05060708);
  endtask

  task automatic test_busy_drop();
    int edges[$];
    logic b21, b22;
    sb.push_back(make_txn(1'b0, 32'h0000_0100, 1'b1, 64'h0));
    sb.push_back(make_txn(1'b0, 32'h0000_0100, 1'b1, 64'h0));
    req = 1'b1; wr = 1'b0; addr = 32'h0000_0100; line128 = 1'b1; wdata = '0;
    b21 = 1'bx; b22 = 1'bx;
    for (int j = 0; j <= 43; j++) begin
      tick();
      if (dready === 1'b1) begin
        edges.push_back(j);
        check_resp("busy_drop");
      end
      if (j == 21) b21 = busy;
      if (j == 22) b22 = busy;
    end
    req = 1'b0;
    tests_run++;
    if (edges.size() != 2 || edges[0] != 20 || edges[1] != 42) begin
      tests_failed++;
      $display("FAIL busy_drop pulses: got %0d pulses first at %0d expected 2 at 20 and 42",
               edges.size(), (edges.size() > 0) ? edges[0] : -1);
    end
    tests_run++;
    if (b21 !== 1'b0 || b22 !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_drop busy: got %b%b expected 01 at k+21,k+22", b21, b22);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    bit seen;
    do_txn("pre_300", 1'b1, 32'h0000_0300, 1'b0, 64'h55555555_66666666);
    req = 1'b1; wr = 1'b1; addr = 32'h0000_0300; line128 = 1'b0; wdata = 64'hAAAAAAAA_BBBBBBBB;
    tick();
    req = 1'b0;
    seen = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (dready === 1'b1) seen = 1'b1;
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || dready !== 1'b0 || rdata !== 128'h0) begin
      tests_failed++;
      $display("FAIL abort reset: busy=%b dready=%b rdata=%h expected 0 0 0", busy, dready, rdata);
    end
    reset = 1'b0;
    model_rdata = '0;
    for (int j = 0; j < LAT + 5; j++) begin
      tick();
      if (dready === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL abort dready: got pulse expected none");
    end
    do_txn("rd_300", 1'b0, 32'h0000_0300, 1'b0, 64'h0);
    tests_run++;
    if (rdata !== {64'h0, 64'h55555555_66666666}) begin
      tests_failed++;
      $display("FAIL abort const: got %h expected 00000000000000005555555566666666", rdata);
    end
  endtask

  task automatic test_reset_priority();
    bit seen;
    req = 1'b1; reset = 1'b1; addr = 32'h0; wr = 1'b0; line128 = 1'b0;
    tick();
    req = 1'b0; reset = 1'b0;
    model_rdata = '0;
    seen = 1'b0;
    for (int j = 0; j < LAT + 5; j++) begin
      tick();
      if (dready === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL reset_priority: got activity expected request dropped");
    end
  endtask

  task automatic test_wrap();
    do_txn("wr_wrap", 1'b1, 32'h0000_4000, 1'b0, 64'h0BADF00D_12345678);
    do_txn("rd_wrap", 1'b0, 32'h0000_0000, 1'b0, 64'h0);
    tests_run++;
    if (rdata !== {64'h0, 64'h0BADF00D_12345678}) begin
      tests_failed++;
      $display("FAIL wrap const: got %h expected 00000000000000000badf00d12345678", rdata);
    end
  endtask

  task automatic test_lat1();
    logic [5:0] dr, bz;
    req1 = 1'b1; wr = 1'b0; addr = 32'h0; line128 = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      dr[j] = dready1;
      bz[j] = busy1;
    end
    req1 = 1'b0;
    tests_run++;
    if (dr !== 6'b010010) begin
      tests_failed++;
      $display("FAIL lat1 dready: got %b expected 010010", dr);
    end
    tests_run++;
    if (bz !== 6'b011011) begin
      tests_failed++;
      $display("FAIL lat1 busy: got %b expected 011011", bz);
    end
    for (int j = 0; j < 4; j++) tick();
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; req = 1'b0; req1 = 1'b0;
    addr = '0; wr = 1'b0; line128 = 1'b0; wdata = '0;
    model_rdata = '0;
    test_reset();
    test_read128();
    test_write_read64();
    test_hold();
    test_busy_drop();
    test_reset_abort();
    test_reset_priority();
    test_wrap();
    test_lat1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
